pooling_stream: RTL and testbench

- Streaming 2x2 stride-2 pooling stage for the feature-map pipeline.
- Accepts one pixel per cycle, carrying all CH channels in parallel, in raster order.
- Buffers even rows in an internal line buffer and emits one pooled pixel per 2x2 window.
- Supports run-time selection between average and max pooling, with valid/ready backpressure on both sides.

---
 rtl/pooling_stream.sv | 152 +++++++++++++++
 tb/tb_pooling_stream.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pooling_stream.sv
// Streaming 2x2 stride-2 pooling stage (average or max) over raster-order pixels.
// Even rows are combined horizontally into a line buffer of partial results. Odd rows
// finish each window against that buffer and register one pooled pixel per window.
module pooling_stream #(
  parameter int unsigned CH    = 64,
  parameter int unsigned DW    = 16,
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned CW      = $clog2(IMG_W);
  localparam int unsigned RW      = $clog2(IMG_H);
  localparam int unsigned LbDepth = IMG_W / 2;
  localparam int unsigned LbAw    = (LbDepth > 1) ? $clog2(LbDepth) : 1;
  // Horizontal partials keep one extra bit so average sums are not lost.
  localparam int unsigned HW      = DW + 1;

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic [CH*DW-1:0] pair_q, pair_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [CH*DW-1:0] out_data_q, out_data_d;

  logic [CH*HW-1:0] linebuf_q [LbDepth];
  logic [CH*HW-1:0] lb_rd;
  logic [LbAw-1:0]  lb_idx;
  logic             lb_we;

  logic [CH*HW-1:0] h_vec;
  logic [CH*DW-1:0] v_vec;

  logic in_fire, out_fire, col_last, row_last, frame_start, win_done;

  assign in_ready    = !out_valid_q || out_ready;
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid_q && out_ready;
  assign col_last    = (col_q == CW'(IMG_W - 1));
  assign row_last    = (row_q == RW'(IMG_H - 1));
  assign frame_start = (col_q == '0) && (row_q == '0);
  assign lb_idx      = LbAw'(col_q >> 1);
  assign lb_rd       = linebuf_q[lb_idx];
  assign lb_we       = in_fire && col_q[0] && !row_q[0];
  assign win_done    = in_fire && col_q[0] && row_q[0];

  // Per-lane combine: horizontal pair first, then vertical against the line buffer.
  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic signed [DW-1:0] p, x, v_avg;
    logic signed [HW-1:0] l, h_sum, h_max, h;
    logic signed [DW+1:0] s;

    assign p     = $signed(pair_q[c*DW +: DW]);
    assign x     = $signed(in_data[c*DW +: DW]);
    assign l     = $signed(lb_rd[c*HW +: HW]);
    assign h_sum = {p[DW-1], p} + {x[DW-1], x};
    assign h_max = (p > x) ? {p[DW-1], p} : {x[DW-1], x};
    assign h     = mode_q ? h_max : h_sum;
    assign s     = {l[HW-1], l} + {h[HW-1], h};
    // Arithmetic shift floors toward -inf; the quotient always fits in DW bits.
    assign v_avg = DW'(s >>> 2);

    assign h_vec[c*HW +: HW] = h;
    assign v_vec[c*DW +: DW] = mode_q ? ((l > h) ? l[DW-1:0] : h[DW-1:0]) : v_avg;
  end

  // Next-state: counters, frame mode latch, pair capture and output register handshake.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    pair_d      = pair_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      if (out_last_q) busy_d = 1'b0;
    end

    if (in_fire) begin
      // A new frame may start in the same cycle the previous last output is taken.
      if (frame_start) begin
        mode_d = mode;
        busy_d = 1'b1;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!col_q[0]) pair_d = in_data;
      // A new result overrides the clear above, so the register reloads seamlessly.
      if (win_done) begin
        out_valid_d = 1'b1;
        out_data_d  = v_vec;
        out_last_d  = col_last && row_last;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Line buffer of even-row horizontal partials; contents need no reset.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf_q[lb_idx] <= h_vec;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pooling_stream.sv
// Self-checking bench for pooling_stream: directed windows plus random frames
// compared against a plain-arithmetic pooling model.
module tb_pooling_stream;

  localparam int CH    = 2;
  localparam int DW    = 16;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int NOUT  = (IMG_W / 2) * (IMG_H / 2);

  typedef struct packed {
    logic [CH*DW-1:0] data;
    logic             last;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [CH*DW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CH*DW-1:0] out_data;
  logic             out_last;
  logic             busy;

  res_t got_q[$];
  res_t exp_q[$];
  int   pix[IMG_H][IMG_W][CH];
  int   checks = 0;
  int   errors = 0;
  bit   rand_on = 1'b0;

  always #5 clk = ~clk;

  pooling_stream #(
    .CH   (CH),
    .DW   (DW),
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  // Inputs only change just after posedge, so the negedge sees the coming handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back('{data: out_data, last: out_last});
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic int floor_div4(input int s);
    int q;
    q = s / 4;
    if ((s % 4) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  // Reference: pool the whole frame held in pix[] with the given mode.
  task automatic push_expected(input logic m);
    for (int pr = 0; pr < IMG_H / 2; pr++) begin
      for (int pc = 0; pc < IMG_W / 2; pc++) begin
        res_t e;
        e.data = '0;
        e.last = (pr == IMG_H / 2 - 1) && (pc == IMG_W / 2 - 1);
        for (int ch = 0; ch < CH; ch++) begin
          int w[4];
          int r;
          w[0] = pix[2*pr][2*pc][ch];
          w[1] = pix[2*pr][2*pc+1][ch];
          w[2] = pix[2*pr+1][2*pc][ch];
          w[3] = pix[2*pr+1][2*pc+1][ch];
          if (m) begin
            r = w[0];
            for (int k = 1; k < 4; k++) if (w[k] > r) r = w[k];
          end else begin
            r = floor_div4(w[0] + w[1] + w[2] + w[3]);
          end
          e.data[ch*DW +: DW] = r[DW-1:0];
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic rand_frame();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        for (int ch = 0; ch < CH; ch++) pix[r][c][ch] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic set_win(input int pr, input int pc, input int ch,
                         input int a, input int b, input int c, input int d);
    pix[2*pr][2*pc][ch]     = a;
    pix[2*pr][2*pc+1][ch]   = b;
    pix[2*pr+1][2*pc][ch]   = c;
    pix[2*pr+1][2*pc+1][ch] = d;
  endtask

  // Offer one pixel and hold it until accepted; returns just after the accepting edge.
  task automatic send_px(input int r, input int c);
    logic acc;
    int   n;
    for (int ch = 0; ch < CH; ch++) begin
      int v;
      v = pix[r][c][ch];
      in_data[ch*DW +: DW] = v[DW-1:0];
    end
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_px r%0d c%0d accepted=%b required=1", r, c, acc);
    end
  endtask

  task automatic send_frame(input logic m, input int toggle_at);
    mode = m;
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      if (i == toggle_at) mode = !m;
      send_px(i / IMG_W, i % IMG_W);
    end
  endtask

  task automatic wait_outputs(input int n);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset out_last got %b want 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset out_data got %h want 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_avg_basic();
    rand_frame();
    set_win(0, 0, 0, 4, 8, 12, 16);
    set_win(0, 0, 1, 0, 0, 0, 3);
    push_expected(1'b0);
    mode = 1'b0;
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      send_px(i / IMG_W, i % IMG_W);
      if (i == 4) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL avg_basic early_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL avg_basic busy got %b want 1", busy); end
      end
      if (i == 5) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL avg_basic latency out_valid got %b want 1", out_valid); end
        checks++; if (out_data[15:0] !== 16'd10) begin errors++; $display("FAIL avg_basic ch0 got %0d want 10", out_data[15:0]); end
        checks++; if (out_data[31:16] !== 16'd0) begin errors++; $display("FAIL avg_basic ch1 got %0d want 0", out_data[31:16]); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL avg_basic first_last got %b want 0", out_last); end
      end
    end
    wait_outputs(NOUT);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL avg_basic busy_end got %b want 0", busy); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL avg_basic count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL avg_basic out%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_avg_edges();
    rand_frame();
    for (int ch = 0; ch < CH; ch++) begin
      set_win(0, 0, ch, -1, -2, -3, -4);
      set_win(0, 1, ch, 32767, 32767, 32767, 32767);
      set_win(1, 0, ch, -32768, -32768, -32768, -32768);
    end
    push_expected(1'b0);
    send_frame(1'b0, -1);
    wait_outputs(NOUT);
    checks++;
    if (got_q.size() < 3) begin
      errors++; $display("FAIL avg_edges count got %0d want >=3", got_q.size());
    end else begin
      if (got_q[0].data[15:0] !== 16'hfffd) begin errors++; $display("FAIL avg_edges neg got %h want fffd", got_q[0].data[15:0]); end
      checks++;
      if (got_q[1].data[15:0] !== 16'h7fff) begin errors++; $display("FAIL avg_edges pos_max got %h want 7fff", got_q[1].data[15:0]); end
      checks++;
      if (got_q[2].data[15:0] !== 16'h8000) begin errors++; $display("FAIL avg_edges neg_min got %h want 8000", got_q[2].data[15:0]); end
    end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL avg_edges count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL avg_edges out%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_max();
    rand_frame();
    for (int ch = 0; ch < CH; ch++) begin
      set_win(0, 0, ch, -5, 3, -7, 2);
      set_win(0, 1, ch, -9, -4, -6, -8);
    end
    push_expected(1'b1);
    send_frame(1'b1, -1);
    wait_outputs(NOUT);
    checks++;
    if (got_q.size() < 2) begin
      errors++; $display("FAIL max count got %0d want >=2", got_q.size());
    end else begin
      if (got_q[0].data[15:0] !== 16'd3) begin errors++; $display("FAIL max win0 got %h want 0003", got_q[0].data[15:0]); end
      checks++;
      if (got_q[1].data[15:0] !== 16'hfffc) begin errors++; $display("FAIL max win1 got %h want fffc", got_q[1].data[15:0]); end
    end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL max count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL max out%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [CH*DW-1:0] held;
    int cyc;
    rand_frame();
    push_expected(1'b0);
    out_ready = 1'b0;
    fork
      send_frame(1'b0, -1);
    join_none
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL backpressure first_valid got %b want 1", out_valid); end
    held = out_data;
    repeat (10) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL backpressure in_ready got %b want 0", in_ready); end
      checks++; if (out_data !== held) begin errors++; $display("FAIL backpressure hold got %h want %h", out_data, held); end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait fork;
    wait_outputs(NOUT);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL backpressure count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL backpressure out%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // Mode flips mid-frame are ignored; the second frame starts with no gap.
  task automatic test_mode_toggle();
    rand_frame();
    push_expected(1'b0);
    send_frame(1'b0, 3);
    rand_frame();
    push_expected(1'b1);
    send_frame(1'b1, 7);
    wait_outputs(2 * NOUT);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mode_toggle count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mode_toggle out%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back_random();
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join_none
    for (int f = 0; f < 4; f++) begin
      logic m;
      m = logic'($urandom_range(0, 1));
      rand_frame();
      push_expected(m);
      send_frame(m, int'($urandom_range(1, IMG_W * IMG_H - 1)));
    end
    rand_on = 1'b0;
    wait fork;
    wait_outputs(4 * NOUT);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random out%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    rand_frame();
    out_ready = 1'b0;
    mode = 1'b0;
    for (int i = 0; i < 6; i++) send_px(i / IMG_W, i % IMG_W);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_mid pending got %b want 1", out_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy got %b want 0", busy); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_mid out_last got %b want 0", out_last); end
    rst = 1'b0;
    out_ready = 1'b1;
    got_q.delete();
    rand_frame();
    push_expected(1'b1);
    send_frame(1'b1, -1);
    wait_outputs(NOUT);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL reset_mid count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid out%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_avg_basic();
    test_avg_edges();
    test_max();
    test_backpressure();
    test_mode_toggle();
    test_back_to_back_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
